// File: rtl/mem_responder.sv
// Multi-channel valid/ready memory responder: each channel accepts one read or write, waits LATENCY
// edges, then pulses ready for one cycle. All channels share one storage array with a separate init port.
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    init_write_enable,
    input  logic [ADDR_BITS-1:0]    init_address,
    input  logic [DATA_BITS-1:0]    init_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RELEASE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         WR_ON    = (WRITE_ENABLE != 0);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    state_t                  state    [NUM_CHANNELS];
    state_t                  state_nx [NUM_CHANNELS];
    logic [3:0]              cnt      [NUM_CHANNELS];
    logic [3:0]              cnt_nx   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    addr     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    addr_nx  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wdata    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wdata_nx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_wr;
    logic [NUM_CHANNELS-1:0] op_wr_nx;
    logic [NUM_CHANNELS-1:0] respond;

    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_nx[ch] = state[ch];
            cnt_nx[ch]   = cnt[ch];
            addr_nx[ch]  = addr[ch];
            wdata_nx[ch] = wdata[ch];
            op_wr_nx[ch] = op_wr[ch];
            respond[ch]  = 1'b0;
            case (state[ch])
                IDLE: begin
                    // Write takes priority; a read still pending is picked up after release.
                    if (WR_ON && mem_write_valid[ch]) begin
                        state_nx[ch] = BUSY;
                        cnt_nx[ch]   = CNT_LOAD;
                        addr_nx[ch]  = mem_write_address[ch];
                        wdata_nx[ch] = mem_write_data[ch];
                        op_wr_nx[ch] = 1'b1;
                    end else if (mem_read_valid[ch]) begin
                        state_nx[ch] = BUSY;
                        cnt_nx[ch]   = CNT_LOAD;
                        addr_nx[ch]  = mem_read_address[ch];
                        op_wr_nx[ch] = 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt[ch] == 4'd0) begin
                        state_nx[ch] = RESPOND;
                        respond[ch]  = 1'b1;
                    end else begin
                        cnt_nx[ch] = cnt[ch] - 4'd1;
                    end
                end
                RESPOND: state_nx[ch] = RELEASE;
                RELEASE: begin
                    // Only the valid that was served must drop before the channel re-arms.
                    if (!(op_wr[ch] ? mem_write_valid[ch] : mem_read_valid[ch]))
                        state_nx[ch] = IDLE;
                end
                default: state_nx[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]         <= IDLE;
                cnt[ch]           <= 4'd0;
                mem_read_data[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]           <= state_nx[ch];
                cnt[ch]             <= cnt_nx[ch];
                mem_read_ready[ch]  <= respond[ch] & ~op_wr[ch];
                mem_write_ready[ch] <= respond[ch] & op_wr[ch] & WR_ON;
                mem_read_data[ch]   <= (respond[ch] && !op_wr[ch]) ? mem[addr[ch]] : '0;
            end
        end
    end

    // Request fields are held from acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            addr[ch]  <= addr_nx[ch];
            wdata[ch] <= wdata_nx[ch];
            op_wr[ch] <= op_wr_nx[ch];
        end
    end

    // Later assignments win: channels in descending order so channel 0 wins, init port last of all.
    always_ff @(posedge clk) begin
        for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
            if (WR_ON && !reset && respond[ch] && op_wr[ch])
                mem[addr[ch]] <= wdata[ch];
        end
        if (init_write_enable)
            mem[init_address] <= init_data;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder: a read/write instance and a read-only 16-bit instance,
// checked against a plain array model of memory contents and the protocol timing rules.
module tb_mem_responder;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rv, rr, wv, wrdy;
    logic [7:0] ra [4];
    logic [7:0] rd [4];
    logic [7:0] wa [4];
    logic [7:0] wd [4];
    logic       iwe;
    logic [7:0] ia, id;

    logic [3:0]  ro_rv, ro_rr, ro_wv, ro_wrdy;
    logic [7:0]  ro_ra [4];
    logic [15:0] ro_rd [4];
    logic [7:0]  ro_wa [4];
    logic [15:0] ro_wd [4];
    logic        ro_iwe;
    logic [7:0]  ro_ia;
    logic [15:0] ro_id;

    logic [7:0] model [256];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(LAT), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rd),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wrdy),
        .init_write_enable(iwe), .init_address(ia), .init_data(id)
    );

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4), .LATENCY(LAT), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .mem_read_valid(ro_rv), .mem_read_address(ro_ra), .mem_read_ready(ro_rr), .mem_read_data(ro_rd),
        .mem_write_valid(ro_wv), .mem_write_address(ro_wa), .mem_write_data(ro_wd), .mem_write_ready(ro_wrdy),
        .init_write_enable(ro_iwe), .init_address(ro_ia), .init_data(ro_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One complete transaction on channel c; checks latency, single-cycle pulse and data clearing.
    task automatic do_op(input int c, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rdata);
        int lat;
        bit seen;
        @(negedge clk);
        if (wr) begin wv[c] = 1'b1; wa[c] = a; wd[c] = d; end
        else    begin rv[c] = 1'b1; ra[c] = a; end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = wr ? wrdy[c] : rr[c];
        end
        rdata = rd[c];
        chk("resp_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(LAT + 1));
        chk("other_ready", 32'(wr ? rr[c] : wrdy[c]), 32'd0);
        if (wr) wv[c] = 1'b0;
        else    rv[c] = 1'b0;
        @(negedge clk);
        chk("pulse_len", 32'(wr ? wrdy[c] : rr[c]), 32'd0);
        if (!wr) chk("rdata_clr", 32'(rd[c]), 32'd0);
        @(negedge clk);
    endtask

    task automatic init_word(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        iwe = 1'b1; ia = a; id = d;
        @(negedge clk);
        iwe = 1'b0;
    endtask

    // Each channel works in its own quarter of the address space, so the model needs no arbitration.
    task automatic rand_master(input int c);
        logic [7:0] a, d, got;
        for (int i = 0; i < 25; i++) begin
            a = {2'(c), 6'($urandom_range(0, 63))};
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_op(c, 1'b1, a, d, got);
                model[a] = d;
            end else begin
                do_op(c, 1'b0, a, 8'h00, got);
                chk("rand_rdata", 32'(got), 32'(model[a]));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g0, g1, g3;
        int pulses, first, lat;
        bit any, seen;

        reset = 1'b1;
        rv = '0; wv = '0; iwe = 1'b0; ia = '0; id = '0;
        ro_rv = '0; ro_wv = '0; ro_iwe = 1'b0; ro_ia = '0; ro_id = '0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = '0; wa[i] = '0; wd[i] = '0;
            ro_ra[i] = '0; ro_wa[i] = '0; ro_wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_rready", 32'(rr[i]), 32'd0);
            chk("rst_wready", 32'(wrdy[i]), 32'd0);
            chk("rst_rdata", 32'(rd[i]), 32'd0);
            chk("rst_ro_rdata", 32'(ro_rd[i]), 32'd0);
        end

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            iwe = 1'b1; ia = 8'(i); id = 8'($urandom);
            model[i] = id;
        end
        @(negedge clk);
        iwe = 1'b0;

        fork
            rand_master(0);
            rand_master(1);
            rand_master(2);
            rand_master(3);
        join

        init_word(8'h10, 8'hAB);
        do_op(0, 1'b0, 8'h10, 8'h00, g0);
        chk("init_read", 32'(g0), 32'hAB);

        do_op(1, 1'b1, 8'h20, 8'h5C, g1);
        do_op(1, 1'b0, 8'h20, 8'h00, g1);
        chk("write_then_read", 32'(g1), 32'h5C);

        fork
            do_op(0, 1'b1, 8'h30, 8'h11, g0);
            do_op(3, 1'b1, 8'h30, 8'h33, g3);
        join
        do_op(1, 1'b0, 8'h30, 8'h00, g1);
        chk("low_ch_wins", 32'(g1), 32'h11);

        init_word(8'h50, 8'hA5);
        fork
            do_op(0, 1'b1, 8'h50, 8'h5A, g0);
            do_op(1, 1'b0, 8'h50, 8'h00, g1);
        join
        chk("rw_same_edge_old", 32'(g1), 32'hA5);
        do_op(2, 1'b0, 8'h50, 8'h00, g1);
        chk("rw_same_edge_new", 32'(g1), 32'h5A);

        fork
            do_op(2, 1'b1, 8'h60, 8'h22, g0);
            begin
                repeat (3) @(negedge clk);
                iwe = 1'b1; ia = 8'h60; id = 8'hEE;
                @(negedge clk);
                iwe = 1'b0;
            end
        join
        do_op(3, 1'b0, 8'h60, 8'h00, g3);
        chk("init_wins", 32'(g3), 32'hEE);

        @(negedge clk);
        rv[2] = 1'b1; ra[2] = 8'h10;
        pulses = 0; first = 0;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (rr[2]) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_first", 32'(first), 32'(LAT + 1));
        rv[2] = 1'b0;
        do_op(2, 1'b0, 8'h10, 8'h00, g0);
        chk("held_reaccept", 32'(g0), 32'hAB);

        init_word(8'h40, 8'h99);
        @(negedge clk);
        wv[0] = 1'b1; wa[0] = 8'h40; wd[0] = 8'h77;
        @(negedge clk);
        reset = 1'b1;
        wv[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_wready", 32'(wrdy[0]), 32'd0);
            chk("midrst_rdata", 32'(rd[0]), 32'd0);
        end
        reset = 1'b0;
        do_op(0, 1'b0, 8'h40, 8'h00, g0);
        chk("midrst_kept", 32'(g0), 32'h99);

        @(negedge clk);
        ro_iwe = 1'b1; ro_ia = 8'h00; ro_id = 16'h1234;
        @(negedge clk);
        ro_iwe = 1'b0;
        ro_wv[0] = 1'b1; ro_wa[0] = 8'h00; ro_wd[0] = 16'hFFFF;
        any = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (ro_wrdy[0] || ro_rr[0]) any = 1'b1;
        end
        chk("ro_no_ready", 32'(any), 32'd0);
        ro_wv[0] = 1'b0;
        @(negedge clk);
        ro_rv[0] = 1'b1; ro_ra[0] = 8'h00;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = ro_rr[0];
        end
        chk("ro_latency", 32'(lat), 32'(LAT + 1));
        chk("ro_rdata", 32'(ro_rd[0]), 32'h1234);
        ro_rv[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
